posit_decode_arb: RTL and testbench

Two-requester arbiter and sequencer for 32-bit posit decoding (es = 3) that time-shares one external 31-bit left-shift unit. It accepts posits from two requesters over valid/ready with round-robin fairness. It performs sign handling and regime run detection, then drives the shared shifter to strip the regime. It returns a tagged, field-split result (sign, regime, exponent, fraction, zero/NaR flags) over a valid/ready output port.

---
 rtl/posit_decode_arb.sv | 204 ++++++++++++++++++++
 tb/tb_posit_decode_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_decode_arb.sv
// posit_decode_arb
//   Two-requester arbiter/sequencer for 32-bit posit decoding (es = 3).
//   Requests are granted round-robin, decoded one at a time (sign handling,
//   regime run detection), and the regime is stripped by an external
//   combinational left shifter before the fields are presented.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (at most one ready high)
//   req_posit0/1         posit operands of requester 0 / 1
//   sh_en, sh_in, sh_k   shared shifter request: sh_out = sh_in << (sh_k+1)
//   sh_out               shifter result (same cycle)
//   out_valid/out_ready  result handshake
//   out_tag              requester index of the result
//   out_sign/zero/nar    sign bit, zero and NaR flags
//   out_regime           signed regime value (-30..30)
//   out_exp, out_frac    exponent field, MSB-aligned fraction (no hidden bit)
module posit_decode_arb #(
    localparam int NREQ = 2,
    localparam int ES   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [31:0]          req_posit0,
    input  logic [31:0]          req_posit1,
    output logic                 sh_en,
    output logic [30:0]          sh_in,
    output logic [4:0]           sh_k,
    input  logic [30:0]          sh_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_tag,
    output logic                 out_sign,
    output logic                 out_zero,
    output logic                 out_nar,
    output logic signed [5:0]    out_regime,
    output logic [ES-1:0]        out_exp,
    output logic [27:0]          out_frac
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOD   = 2'd1,
        SHIFT = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic                tag_q, tag_d;
    logic                sign_q, sign_d;
    logic                zero_q, zero_d;
    logic                nar_q, nar_d;
    logic signed [5:0]   regime_q, regime_d;
    logic [ES-1:0]       exp_q, exp_d;
    logic [27:0]         frac_q, frac_d;
    logic [31:0]         p_q, p_d;
    logic [30:0]         body_q, body_d;
    logic [4:0]          shk_q, shk_d;

    logic                gnt;
    logic                accept;
    logic [30:0]         body;
    logic [4:0]          run;

    // Length of the run of bits equal to body[30], scanning down from bit 30.
    // Inverting a leading-one body turns the run into leading zeros.
    function automatic logic [4:0] run_len(input logic [30:0] b);
        logic [30:0] x;
        logic [4:0]  n;
        logic        done;
        x    = b[30] ? ~b : b;
        n    = 5'd0;
        done = 1'b0;
        for (int i = 30; i >= 0; i--) begin
            if (!done && !x[i]) n = n + 5'd1;
            else                done = 1'b1;
        end
        return n;
    endfunction

    // Run of ones encodes r-1, run of zeros encodes -r.
    function automatic logic signed [5:0] regime_of(input logic lead, input logic [4:0] r);
        logic signed [5:0] rs;
        rs = $signed({1'b0, r});
        return lead ? (rs - 6'sd1) : (-rs);
    endfunction

    // Both requesting: favour the lane that did not finish last.
    assign gnt    = (req_valid == 2'b11) ? ~rr_q : req_valid[1];
    assign accept = |(req_valid & req_ready);

    // Gated by rst_n so ready falls as soon as reset is asserted.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && state_q == IDLE && |req_valid)
            req_ready = gnt ? 2'b10 : 2'b01;
    end

    // Two's complement of the low 31 bits equals the low 31 bits of -p.
    assign body = p_q[31] ? (~p_q[30:0] + 31'd1) : p_q[30:0];
    assign run  = run_len(body);

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        tag_d    = tag_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        nar_d    = nar_q;
        regime_d = regime_q;
        exp_d    = exp_q;
        frac_d   = frac_q;
        p_d      = p_q;
        body_d   = body_q;
        shk_d    = shk_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    p_d     = gnt ? req_posit1 : req_posit0;
                    tag_d   = gnt;
                    state_d = LOD;
                end
            end
            LOD: begin
                sign_d = p_q[31];
                if (p_q[30:0] == 31'd0) begin
                    zero_d   = ~p_q[31];
                    nar_d    = p_q[31];
                    regime_d = 6'sd0;
                    exp_d    = '0;
                    frac_d   = 28'd0;
                    state_d  = OUT;
                end else begin
                    zero_d   = 1'b0;
                    nar_d    = 1'b0;
                    regime_d = regime_of(body[30], run);
                    body_d   = body;
                    // A full-width run has no terminator; shifting by 31 clears all.
                    shk_d    = (run == 5'd31) ? 5'd30 : run;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                exp_d   = sh_out[30:28];
                frac_d  = sh_out[27:0];
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    rr_d    = tag_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= 1'b1;
            tag_q    <= 1'b0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            nar_q    <= 1'b0;
            regime_q <= 6'sd0;
            exp_q    <= '0;
            frac_q   <= 28'd0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            tag_q    <= tag_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            nar_q    <= nar_d;
            regime_q <= regime_d;
            exp_q    <= exp_d;
            frac_q   <= frac_d;
        end
    end

    // Operand holding registers; never observed outside the states that load them.
    always_ff @(posedge clk) begin
        p_q    <= p_d;
        body_q <= body_d;
        shk_q  <= shk_d;
    end

    assign sh_en      = (state_q == SHIFT);
    assign sh_in      = sh_en ? body_q : 31'd0;
    assign sh_k       = sh_en ? shk_q : 5'd31;
    assign out_valid  = (state_q == OUT);
    assign out_tag    = tag_q;
    assign out_sign   = sign_q;
    assign out_zero   = zero_q;
    assign out_nar    = nar_q;
    assign out_regime = regime_q;
    assign out_exp    = exp_q;
    assign out_frac   = frac_q;

endmodule

// File: tb/tb_posit_decode_arb.sv
module tb_posit_decode_arb;

    logic               clk;
    logic               rst_n;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [31:0]        req_posit0;
    logic [31:0]        req_posit1;
    logic               sh_en;
    logic [30:0]        sh_in;
    logic [4:0]         sh_k;
    logic [30:0]        sh_out;
    logic               out_valid;
    logic               out_ready;
    logic               out_tag;
    logic               out_sign;
    logic               out_zero;
    logic               out_nar;
    logic signed [5:0]  out_regime;
    logic [2:0]         out_exp;
    logic [27:0]        out_frac;

    posit_decode_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_posit0 (req_posit0),
        .req_posit1 (req_posit1),
        .sh_en      (sh_en),
        .sh_in      (sh_in),
        .sh_k       (sh_k),
        .sh_out     (sh_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_sign   (out_sign),
        .out_zero   (out_zero),
        .out_nar    (out_nar),
        .out_regime (out_regime),
        .out_exp    (out_exp),
        .out_frac   (out_frac)
    );

    // External shifter: sh_in << (sh_k+1); a shift of 32 gives zero.
    logic [31:0] sh_wide;
    assign sh_wide = {1'b0, sh_in} << (32'(sh_k) + 32'd1);
    assign sh_out  = sh_wide[30:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        tag;
        logic        sign;
        logic        zero;
        logic        nar;
        logic [5:0]  regime;
        logic [2:0]  exp;
        logic [27:0] frac;
    } res_t;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   prev_hs = 1'b0;
    logic [4:0] last_shk = 5'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bit-walking reference decoder.
    function automatic res_t model(input logic [31:0] p, input logic tag);
        res_t        r;
        logic [31:0] v;
        logic        lead;
        int          i;
        int          run;
        r      = '0;
        r.tag  = tag;
        r.sign = p[31];
        if (p[30:0] == 31'd0) begin
            r.zero = ~p[31];
            r.nar  = p[31];
            return r;
        end
        v    = p[31] ? (~p + 32'd1) : p;
        lead = v[30];
        i    = 30;
        run  = 0;
        while (i >= 0 && v[i] == lead) begin
            run++;
            i--;
        end
        r.regime = lead ? 6'(run - 1) : 6'(-run);
        i--;
        for (int b = 2; b >= 0; b--) begin
            r.exp[b] = (i >= 0) ? v[i] : 1'b0;
            i--;
        end
        for (int b = 27; b >= 0; b--) begin
            r.frac[b] = (i >= 0) ? v[i] : 1'b0;
            i--;
        end
        return r;
    endfunction

    // Monitor: push expectations at request handshakes, compare at result handshakes.
    always @(negedge clk) begin
        res_t e;
        chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        if (prev_hs) chk("ready_pulse", 64'(req_ready), 64'd0);
        if (!sh_en) begin
            chk("sh_k_idle", 64'(sh_k), 64'd31);
            chk("sh_in_idle", 64'(sh_in), 64'd0);
        end else begin
            last_shk = sh_k;
        end
        if (|(req_valid & req_ready))
            sb.push_back(model(req_ready[1] ? req_posit1 : req_posit0, req_ready[1]));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("tag",    64'(out_tag),  64'(e.tag));
                chk("sign",   64'(out_sign), 64'(e.sign));
                chk("zero",   64'(out_zero), 64'(e.zero));
                chk("nar",    64'(out_nar),  64'(e.nar));
                chk("regime", {58'd0, out_regime}, {58'd0, e.regime});
                chk("exp",    64'(out_exp),  64'(e.exp));
                chk("frac",   64'(out_frac), 64'(e.frac));
            end
        end
        prev_hs = |(req_valid & req_ready);
    end

    // Called with the block idle just after a rising edge; latency counts edges from here.
    task automatic send_one(input int lane, input logic [31:0] p, input bit special);
        int lat;
        if (lane == 0) req_posit0 = p; else req_posit1 = p;
        req_valid[lane] = 1'b1;
        @(negedge clk);
        chk("accept", 64'(req_ready[lane]), 64'd1);
        @(posedge clk); #1;
        req_valid[lane] = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), special ? 64'd2 : 64'd3);
        @(posedge clk); #1;
    endtask

    logic [31:0] arb0 [4] = '{32'h40000000, 32'h7FFFFFFF, 32'h00000000, 32'h12345678};
    logic [31:0] arb1 [4] = '{32'hC0000000, 32'h80000000, 32'h00000001, 32'hA5A5A5A5};

    initial begin
        int   cnt0;
        int   cnt1;
        int   nacc;
        int   k;
        logic [1:0]  hs;
        logic [63:0] snap;

        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_posit0 = 32'h0;
        req_posit1 = 32'h0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_ready",  64'(req_ready), 64'd0);
        chk("rst_valid",  64'(out_valid), 64'd0);
        chk("rst_sh_en",  64'(sh_en), 64'd0);
        chk("rst_sh_k",   64'(sh_k), 64'd31);
        chk("rst_fields", {23'd0, out_tag, out_sign, out_zero, out_nar, out_regime, out_exp, out_frac}, 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed decodes
        send_one(0, 32'h40000000, 1'b0);
        send_one(0, 32'h48000000, 1'b0);
        send_one(0, 32'hC0000000, 1'b0);
        last_shk = 5'd0;
        send_one(1, 32'h7FFFFFFF, 1'b0);
        chk("shk_max_run", 64'(last_shk), 64'd30);
        send_one(0, 32'h00000001, 1'b0);
        send_one(1, 32'h00000000, 1'b1);
        send_one(1, 32'h80000000, 1'b1);

        // Arbitration: both lanes hold valid; last finisher was lane 1
        cnt0 = 0; cnt1 = 0; nacc = 0;
        req_posit0 = arb0[0];
        req_posit1 = arb1[0];
        req_valid  = 2'b11;
        for (int cyc = 0; cyc < 200 && (cnt0 < 4 || cnt1 < 4); cyc++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            if (hs[0]) begin
                chk("arb_order", 64'd0, 64'(nacc % 2));
                nacc++; cnt0++;
                if (cnt0 < 4) req_posit0 = arb0[cnt0]; else req_valid[0] = 1'b0;
            end
            if (hs[1]) begin
                chk("arb_order", 64'd1, 64'(nacc % 2));
                nacc++; cnt1++;
                if (cnt1 < 4) req_posit1 = arb1[cnt1]; else req_valid[1] = 1'b0;
            end
        end
        chk("arb_count", 64'(nacc), 64'd8);
        repeat (6) @(posedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);

        // Back-pressure with a competing request pending
        out_ready  = 1'b0;
        req_posit0 = 32'h48000000;
        req_valid  = 2'b01;
        @(negedge clk);
        chk("bp_accept", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        req_posit1 = 32'h7FFFFFFF;
        req_valid  = 2'b10;
        k = 0;
        while (!out_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        snap = {23'd0, out_tag, out_sign, out_zero, out_nar, out_regime, out_exp, out_frac};
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_hold", {23'd0, out_tag, out_sign, out_zero, out_nar, out_regime, out_exp, out_frac}, snap);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Reset while the lane-1 decode is in SHIFT
        k = 0;
        while (!sh_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reach_shift", 64'(sh_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_sh_k",  64'(sh_k), 64'd31);
        chk("rst_mid_sh_en", 64'(sh_en), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        chk("rst_mid_fields", {23'd0, out_tag, out_sign, out_zero, out_nar, out_regime, out_exp, out_frac}, 64'd0);
        req_valid = 2'b00;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_one(0, 32'hC0000000, 1'b0);
        send_one(1, 32'h00000001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_final", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
